// File: rtl/acc_dec_if.sv
// acc_dec port bundle: serial y/iclk in, valid/ready word out plus status.
// master drives y/iclk/ready (link side + consumer), slave is the decoder.
interface acc_dec_if #(
    parameter int WIDTH = 8
);
    logic                          y;
    logic                          iclk;
    logic [WIDTH-1:0]              data;
    logic                          valid;
    logic                          ready;
    logic                          overrun;
    logic                          parity_err;
    logic [$clog2(WIDTH+2)-1:0]    bit_cnt;

    modport master (
        output y, iclk, ready,
        input  data, valid, overrun, parity_err, bit_cnt
    );

    modport slave (
        input  y, iclk, ready,
        output data, valid, overrun, parity_err, bit_cnt
    );
endinterface

// File: rtl/acc_dec.sv
// Undoes the acc toggle accumulator and packs bits LSB-first; ACC_DEC_PARITY_EN adds even parity.
// valid 1 clk after final strobe; single-word hold buffer, words completing while held are dropped (sticky overrun).
module acc_dec #(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    acc_dec_if.slave  bus
);
`ifdef ACC_DEC_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);
    localparam int AW = FL - 1;

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic           r_iclk_q;
    logic           r_y_prev;
    logic [AW-1:0]  r_asm;
    logic [CW-1:0]  r_bit_cnt;
    logic [WIDTH-1:0] r_data;
    logic [0:0]     r_state;
    logic           r_overrun;

    logic           w_strobe;
    logic           w_bit;
    logic           w_done;
    logic           w_load;
    logic [FL-1:0]  w_frame;

    assign w_strobe = bus.iclk & ~r_iclk_q;
    assign w_bit    = bus.y ^ r_y_prev;
    assign w_done   = w_strobe && (r_bit_cnt == CW'(FL - 1));
    // Earlier bits sit at the bottom of r_asm once FL-1 shifts have happened.
    assign w_frame  = {w_bit, r_asm};
    assign w_load   = w_done && ((r_state == EMPTY) || bus.ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iclk_q  <= 1'b0;
            r_y_prev  <= 1'b0;
            r_asm     <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_iclk_q <= bus.iclk;
            if (w_strobe) begin
                r_y_prev  <= bus.y;
                r_asm     <= AW'(w_frame >> 1);
                r_bit_cnt <= w_done ? '0 : r_bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= EMPTY;
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_data  <= w_frame[WIDTH-1:0];
                r_state <= FULL;
            end else if ((r_state == FULL) && bus.ready) begin
                r_state <= EMPTY;
            end
            if (w_done && (r_state == FULL) && !bus.ready) begin
                r_overrun <= 1'b1;
            end
        end
    end

`ifdef ACC_DEC_PARITY_EN
    logic r_parity_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else if (w_load) begin
            r_parity_err <= ^w_frame;
        end
    end

    assign bus.parity_err = r_parity_err;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.data    = r_data;
    assign bus.valid   = (r_state == FULL);
    assign bus.overrun = r_overrun;
    assign bus.bit_cnt = r_bit_cnt;
endmodule
